// File: rtl/apb_master_arbiter.sv
// Round-robin APB master: shares one APB bus between NUM_REQ requesters,
// sequences IDLE -> SETUP -> ACCESS and aborts transfers stuck in wait states.
module apb_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          PSELx,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state_q,     state_d;
  logic [IW-1:0]         last_q,      last_d;
  logic [IW-1:0]         owner_q,     owner_d;
  logic [WW-1:0]         wdog_q,      wdog_d;
  logic                  pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;

  logic                  grant_found;
  logic [IW-1:0]         grant_idx;
  logic [IW-1:0]         cand;

  // Round-robin search starting one past the last winner.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    wdog_d      = wdog_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    req_ready   = '0;

    case (state_q)
      ST_IDLE: begin
        // req_ready is a same-cycle acknowledge; the request is captured on this edge.
        if (grant_found && !PRESET) begin
          req_ready[grant_idx] = 1'b1;
          pwrite_d = req_write[grant_idx];
          paddr_d  = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          pwdata_d = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          last_d   = grant_idx;
          owner_d  = grant_idx;
          wdog_d   = '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          state_d     = ST_IDLE;
        end else if (wdog_q == WDOG_MAX) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (PRESET) begin
      state_q     <= ST_IDLE;
      last_q      <= LAST_RST;
      owner_q     <= '0;
      wdog_q      <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      wdog_q      <= wdog_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSELx     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: transfer-level model compared every
// cycle, plus literal expectations for reset, latency, round-robin and timeout.
module tb_apb_master_arbiter;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 16;

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic [NR-1:0]    req_valid, req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err, PSELx, PENABLE, PWRITE;
  logic [AW-1:0]    PADDR;
  logic [DW-1:0]    PWDATA, PRDATA;
  logic             PREADY;

  apb_master_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- requesters and slave ----------------
  int            pend[NR];
  logic [AW-1:0] r_addr[NR];
  logic [DW-1:0] r_wdata[NR];
  logic          r_write[NR];
  int            wait_wr, wait_rd, acc_n;
  logic [NR-1:0] gr_seen = '0;

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]             = (pend[i] > 0);
      req_write[i]             = r_write[i];
      req_addr[i*AW +: AW]     = r_addr[i];
      req_wdata[i*DW +: DW]    = r_wdata[i];
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
    for (int i = 0; i < NR; i++)
      if (gr_seen[i] && pend[i] > 0) pend[i]--;
    drive_reqs();
    if (PENABLE) begin
      PREADY = (acc_n >= (PWRITE ? wait_wr : wait_rd));
      acc_n++;
    end else begin
      PREADY = 1'b0;
      acc_n  = 0;
    end
  endtask

  function automatic bit pend_zero();
    for (int i = 0; i < NR; i++)
      if (pend[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input int bound, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(pend_zero() && !PSELx) && n < bound);
    check({name, "_completes"}, 64'(pend_zero() && !PSELx), 64'd1);
    step();
  endtask

  // ---------------- transfer-level model ----------------
  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  bit            m_busy = 1'b0;
  int            m_t = 0, m_owner = 0, m_last = NR - 1;
  logic          m_w = 1'b0;
  logic [AW-1:0] m_a = '0;
  logic [DW-1:0] m_d = '0;
  logic [NR-1:0] m_rv = '0;
  logic [DW-1:0] m_rd = '0;
  logic          m_re = 1'b0;

  typedef struct {
    int idx;
    int cyc;
  } grant_t;
  typedef struct {
    logic [NR-1:0] v;
    logic [DW-1:0] rd;
    logic          err;
    int            acc;
    int            cyc;
    logic          psel;
    logic          pw;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
  } rsp_t;
  grant_t glog[$];
  rsp_t   rlog[$];
  int     cyc = 0;
  int     acc_cnt = 0;

  always @(negedge PCLK) begin
    int            w;
    logic [NR-1:0] e_rdy;
    cyc++;
    gr_seen = req_ready;
    w = -1;
    e_rdy = '0;
    if (!m_busy && !PRESET) begin
      w = rr_pick(req_valid, m_last);
      if (w >= 0) e_rdy[w] = 1'b1;
    end
    check("req_ready", 64'(req_ready), 64'(e_rdy));
    check("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    check("rsp_rdata", 64'(rsp_rdata), 64'(m_rd));
    check("rsp_err",   64'(rsp_err),   64'(m_re));
    check("PSELx",     64'(PSELx),     64'(m_busy));
    check("PENABLE",   64'(PENABLE),   64'(m_busy && m_t >= 2));
    check("PWRITE",    64'(PWRITE),    64'(m_w));
    check("PADDR",     64'(PADDR),     64'(m_a));
    check("PWDATA",    64'(PWDATA),    64'(m_d));

    // observation logs for the literal checks
    if (PSELx && !PENABLE) acc_cnt = 0;
    if (PENABLE) acc_cnt++;
    for (int i = 0; i < NR; i++)
      if (req_ready[i]) glog.push_back('{idx: i, cyc: cyc});
    if (rsp_valid != '0)
      rlog.push_back('{v: rsp_valid, rd: rsp_rdata, err: rsp_err, acc: acc_cnt, cyc: cyc,
                       psel: PSELx, pw: PWRITE, pa: PADDR, pd: PWDATA});

    // what the upcoming edge must do
    if (PRESET) begin
      m_busy = 1'b0; m_t = 0; m_last = NR - 1;
      m_w = 1'b0; m_a = '0; m_d = '0;
      m_rv = '0; m_rd = '0; m_re = 1'b0;
    end else begin
      m_rv = '0; m_rd = '0; m_re = 1'b0;
      if (!m_busy) begin
        if (w >= 0) begin
          m_busy = 1'b1; m_t = 1; m_owner = w; m_last = w;
          m_w = req_write[w];
          m_a = req_addr[w*AW +: AW];
          m_d = req_wdata[w*DW +: DW];
        end
      end else if (m_t == 1) begin
        m_t = 2;
      end else if (PREADY) begin
        m_rv[m_owner] = 1'b1;
        m_rd = m_w ? '0 : PRDATA;
        m_busy = 1'b0;
      end else if (m_t - 2 == TO - 1) begin
        m_rv[m_owner] = 1'b1;
        m_re = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_t++;
      end
    end
  end

  function automatic int g_idx(input int n);
    return (n < glog.size()) ? glog[n].idx : -1;
  endfunction
  function automatic int g_cyc(input int n);
    return (n < glog.size()) ? glog[n].cyc : -1000;
  endfunction
  function automatic rsp_t r_get(input int n);
    rsp_t r;
    r = '{v: '0, rd: '0, err: 1'b0, acc: -1, cyc: -1000, psel: 1'b1, pw: 1'b0, pa: '0, pd: '0};
    if (n < rlog.size()) r = rlog[n];
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rsp_t r;
    int   base, rbase, rcount;
    PRESET = 1'b1; PREADY = 1'b0; PRDATA = 8'h5A; acc_n = 0;
    wait_wr = 0; wait_rd = 2;
    pend = '{1, 1};
    r_addr[0] = 4'h3; r_wdata[0] = 8'hA5; r_write[0] = 1'b1;
    r_addr[1] = 4'hC; r_wdata[1] = 8'h00; r_write[1] = 1'b0;
    drive_reqs();

    // reset with both requesters pending
    step();
    @(negedge PCLK);
    check("reset_outputs_zero",
          64'({req_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PWRITE, PADDR, PWDATA}), 64'd0);
    step();
    PRESET = 1'b0;

    // write from req0, then read from req1 with two wait states
    wait_done(40, "phase_a");
    check("a_first_grant_req0", 64'(g_idx(0)), 64'd0);
    check("a_second_grant_req1", 64'(g_idx(1)), 64'd1);
    r = r_get(0);
    check("a_wr_rsp_valid", 64'(r.v), 64'h1);
    check("a_wr_latency", 64'(r.cyc - g_cyc(0)), 64'd3);
    check("a_wr_access_len", 64'(r.acc), 64'd1);
    check("a_wr_bus", 64'({r.pw, r.pa, r.pd}), 64'({1'b1, 4'h3, 8'hA5}));
    check("a_wr_rdata", 64'(r.rd), 64'h0);
    r = r_get(1);
    check("a_rd_rsp_valid", 64'(r.v), 64'h2);
    check("a_rd_rdata", 64'(r.rd), 64'h5A);
    check("a_rd_err", 64'(r.err), 64'd0);
    check("a_rd_access_len", 64'(r.acc), 64'd3);
    check("a_rd_latency", 64'(r.cyc - g_cyc(1)), 64'd5);

    // round robin with both requesters held valid for two transfers each
    base = glog.size();
    wait_wr = 0; wait_rd = 0;
    r_addr[0] = 4'h1; r_wdata[0] = 8'h11; r_write[0] = 1'b1;
    r_addr[1] = 4'h2; r_wdata[1] = 8'h22; r_write[1] = 1'b1;
    pend = '{2, 2};
    drive_reqs();
    wait_done(60, "phase_b");
    check("b_grant_count", 64'(glog.size() - base), 64'd4);
    check("b_order_0", 64'(g_idx(base)),     64'd0);
    check("b_order_1", 64'(g_idx(base + 1)), 64'd1);
    check("b_order_2", 64'(g_idx(base + 2)), 64'd0);
    check("b_order_3", 64'(g_idx(base + 3)), 64'd1);
    check("b_grant_spacing", 64'(g_cyc(base + 1) - g_cyc(base)), 64'd3);

    // watchdog abort with PREADY stuck low
    rbase = rlog.size();
    r_addr[0] = 4'h7; r_write[0] = 1'b0;
    wait_rd = 1000;
    pend = '{1, 0};
    drive_reqs();
    wait_done(60, "phase_c");
    r = r_get(rbase);
    check("c_timeout_access_len", 64'(r.acc), 64'd16);
    check("c_timeout_err", 64'(r.err), 64'd1);
    check("c_timeout_rdata", 64'(r.rd), 64'h0);
    check("c_timeout_valid", 64'(r.v), 64'h1);
    check("c_timeout_psel", 64'(r.psel), 64'd0);

    // reset in the middle of req0's wait states
    r_addr[0] = 4'h9;
    pend = '{1, 0};
    drive_reqs();
    for (int i = 0; i < 20 && acc_n < 3; i++) step();
    check("d_reached_wait_state", 64'(acc_n >= 3), 64'd1);
    rcount = rlog.size();
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    check("d_bus_dropped", 64'({PSELx, PENABLE}), 64'd0);
    base = glog.size();
    step();
    step();
    check("d_no_rsp_for_killed", 64'(rlog.size()), 64'(rcount));
    wait_rd = 0; wait_wr = 0;
    r_write[1] = 1'b1; r_addr[1] = 4'h5; r_wdata[1] = 8'h3C;
    pend = '{1, 1};
    drive_reqs();
    wait_done(40, "phase_d");
    check("d_priority_back_to_req0", 64'(g_idx(base)), 64'd0);
    check("d_then_req1", 64'(g_idx(base + 1)), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
